// File: rtl/clock_gate_pkg.sv
// Shared types and defaults for the idle-driven clock gating controller.
// Channel state encoding plus default parameter values used by the top.
package clock_gate_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_ON   = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } gate_state_t;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_IDLE_W      = 8;
  localparam int DEF_WAKE_CYCLES = 2;

endpackage

// File: rtl/clock_gate_cell.sv
// Glitch-free gate: enable latched during clk low, ANDed with clk.
// Zero-cycle path; an enable change only affects the next full high phase.
module clock_gate_cell (
  input  logic clk,
  input  logic en,
  output logic gated_clk
);

  logic en_lat;

  always_latch begin
    if (!clk) en_lat <= en;
  end

  assign gated_clk = clk & en_lat;

endmodule

// File: rtl/clock_gate_ctrl.sv
// Per-channel idle counter / ON-OFF-WAKE FSM driving one gate cell each.
// clk_en and wake_ack are registered; WAKE runs WAKE_CYCLES edges before ack.
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int IDLE_W      = DEF_IDLE_W,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDLE_W-1:0] i__idle_threshold,
  input  logic [NUM_CH-1:0] i__busy,
  input  logic [NUM_CH-1:0] i__force_on,
  input  logic [NUM_CH-1:0] i__wake_req,
  output logic [NUM_CH-1:0] o__wake_ack,
  output logic [NUM_CH-1:0] o__clk_en,
  output logic [NUM_CH-1:0] o__gated_clk
);

  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = '1;

  logic [IDLE_W-1:0] thr_m1;
  logic              thr_on;

  // Gating fires on the idle cycle whose count already reached threshold-1.
  assign thr_m1 = i__idle_threshold - IDLE_W'(1);
  assign thr_on = |i__idle_threshold;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    gate_state_t       state, state_n;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;
    logic [WAKE_W-1:0] wake_cnt, wake_cnt_n;
    logic              clk_en_q, ack_q, act;

    assign act = i__busy[g] | i__force_on[g] | i__wake_req[g];

    always_comb begin
      state_n    = state;
      idle_cnt_n = idle_cnt;
      wake_cnt_n = wake_cnt;
      case (state)
        ST_ON: begin
          if (act) begin
            idle_cnt_n = '0;
          end else if (thr_on && (idle_cnt >= thr_m1)) begin
            state_n    = ST_OFF;
            idle_cnt_n = '0;
          end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt_n = idle_cnt + IDLE_W'(1);
          end
        end
        ST_OFF: begin
          idle_cnt_n = '0;
          if (act) begin
            state_n    = ST_WAKE;
            wake_cnt_n = '0;
          end
        end
        ST_WAKE: begin
          // Inputs are ignored here so a wake always runs to completion.
          wake_cnt_n = wake_cnt + WAKE_W'(1);
          if (wake_cnt == WAKE_LAST) begin
            state_n    = ST_ON;
            idle_cnt_n = '0;
          end
        end
        default: begin
          state_n    = ST_ON;
          idle_cnt_n = '0;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= ST_ON;
        idle_cnt <= '0;
        wake_cnt <= '0;
        clk_en_q <= 1'b1;
        ack_q    <= 1'b0;
      end else begin
        state    <= state_n;
        idle_cnt <= idle_cnt_n;
        wake_cnt <= wake_cnt_n;
        clk_en_q <= (state_n != ST_OFF);
        ack_q    <= (state_n == ST_ON) & i__wake_req[g];
      end
    end

    assign o__clk_en[g]   = clk_en_q;
    assign o__wake_ack[g] = ack_q;

    clock_gate_cell u_cell (
      .clk       (clk),
      .en        (clk_en_q),
      .gated_clk (o__gated_clk[g])
    );
  end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Randomised and directed bench for clock_gate_ctrl against a behavioural channel model.
// Also watches every gated clock edge for truncated or glitching pulses.
module tb_clock_gate_ctrl;

  localparam int NCH  = 4;
  localparam int WAKE = 2;
  localparam int HALF = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     thr;
  logic [NCH-1:0] busy, force_on, wake_req;
  logic [NCH-1:0] ack, clk_en, gated_clk;

  int errors = 0;
  int checks = 0;

  clock_gate_ctrl #(.NUM_CH(NCH), .IDLE_W(8), .WAKE_CYCLES(WAKE)) dut (
    .clk               (clk),
    .rst               (rst),
    .i__idle_threshold (thr),
    .i__busy           (busy),
    .i__force_on       (force_on),
    .i__wake_req       (wake_req),
    .o__wake_ack       (ack),
    .o__clk_en         (clk_en),
    .o__gated_clk      (gated_clk)
  );

  always #HALF clk = ~clk;

  // Pulse monitor: every gated rise must coincide with clk rising, every fall with clk falling.
  int             glitches = 0;
  int             pulses [NCH];
  time            rise_t [NCH];
  logic [NCH-1:0] rise_seen = '0;
  logic [NCH-1:0] prev_g = '0;

  always @(gated_clk) begin
    for (int g = 0; g < NCH; g++) begin
      if (!$isunknown(gated_clk[g]) && !$isunknown(prev_g[g]) && gated_clk[g] !== prev_g[g]) begin
        if (gated_clk[g]) begin
          rise_t[g]    = $time;
          rise_seen[g] = 1'b1;
          pulses[g]    = pulses[g] + 1;
          if (clk !== 1'b1) glitches = glitches + 1;
        end else if (clk !== 1'b0 || (rise_seen[g] && ($time - rise_t[g]) != HALF)) begin
          glitches = glitches + 1;
        end
      end
    end
    prev_g = gated_clk;
  end

  // Behavioural model: a channel is gated, waking (cycles left), or running with an idle streak.
  logic [NCH-1:0] m_off;
  int             m_wleft [NCH];
  int             m_streak [NCH];
  logic [NCH-1:0] m_en, m_ack;

  task automatic model_reset();
    for (int g = 0; g < NCH; g++) begin
      m_off[g]    = 1'b0;
      m_wleft[g]  = 0;
      m_streak[g] = 0;
    end
    m_en  = '1;
    m_ack = '0;
  endtask

  task automatic model_step();
    for (int g = 0; g < NCH; g++) begin
      logic act;
      act = busy[g] | force_on[g] | wake_req[g];
      if (m_wleft[g] > 0) begin
        m_wleft[g]  = m_wleft[g] - 1;
        m_streak[g] = 0;
      end else if (m_off[g]) begin
        if (act) begin
          m_off[g]   = 1'b0;
          m_wleft[g] = WAKE;
        end
      end else if (act) begin
        m_streak[g] = 0;
      end else begin
        m_streak[g] = m_streak[g] + 1;
        if (thr != 0 && m_streak[g] >= int'(thr)) begin
          m_off[g]    = 1'b1;
          m_streak[g] = 0;
        end
      end
      m_en[g]  = !m_off[g];
      m_ack[g] = !m_off[g] && (m_wleft[g] == 0) && wake_req[g];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int base;
    thr = 8'd4; busy = '0; force_on = '0; wake_req = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (clk_en !== 4'hF) begin errors++; $display("FAIL reset_clk_en: got %h want f", clk_en); end
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL reset_ack: got %h want 0", ack); end
    @(negedge clk);
    rst  = 1'b0;
    base = pulses[0];
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++; if (clk_en !== m_en) begin errors++; $display("FAIL reset_seq_en[%0d]: got %h want %h", i, clk_en, m_en); end
      if (i == 3) begin
        checks++; if (clk_en[0] !== 1'b1) begin errors++; $display("FAIL reset_en_edge3: got %b want 1", clk_en[0]); end
      end
      if (i == 4) begin
        checks++; if (clk_en[0] !== 1'b0) begin errors++; $display("FAIL reset_en_edge4: got %b want 0", clk_en[0]); end
      end
    end
    checks++; if (pulses[0] - base != 4) begin errors++; $display("FAIL reset_pulse_count: got %0d want 4", pulses[0] - base); end
  endtask

  task automatic test_idle_restart();
    do_reset();
    thr = 8'd3;
    for (int i = 1; i <= 8; i++) begin
      busy[1] = (i == 3);
      tick();
      checks++; if (clk_en !== m_en) begin errors++; $display("FAIL restart_en[%0d]: got %h want %h", i, clk_en, m_en); end
      if (i == 3) begin
        checks++; if (clk_en !== 4'b0010) begin errors++; $display("FAIL restart_others_gate: got %h want 2", clk_en); end
      end
      if (i == 5) begin
        checks++; if (clk_en[1] !== 1'b1) begin errors++; $display("FAIL restart_ch1_edge5: got %b want 1", clk_en[1]); end
      end
      if (i == 6) begin
        checks++; if (clk_en[1] !== 1'b0) begin errors++; $display("FAIL restart_ch1_edge6: got %b want 0", clk_en[1]); end
      end
    end
    busy = '0;
  endtask

  task automatic test_wake_handshake();
    logic [1:0] exp_ack;
    wake_req[2] = 1'b1;
    exp_ack = 2'b00;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i >= 3) exp_ack = 2'b11;
      checks++; if (clk_en[2] !== 1'b1) begin errors++; $display("FAIL wake_en[%0d]: got %b want 1", i, clk_en[2]); end
      checks++; if (ack[2] !== exp_ack[0]) begin errors++; $display("FAIL wake_ack[%0d]: got %b want %b", i, ack[2], exp_ack[0]); end
      checks++; if (ack !== m_ack) begin errors++; $display("FAIL wake_ack_model[%0d]: got %h want %h", i, ack, m_ack); end
    end
    wake_req[2] = 1'b0;
    tick();
    checks++; if (ack[2] !== 1'b0) begin errors++; $display("FAIL wake_ack_drop: got %b want 0", ack[2]); end
    tick();
    checks++; if (clk_en[2] !== 1'b1) begin errors++; $display("FAIL wake_regate_early: got %b want 1", clk_en[2]); end
    tick();
    checks++; if (clk_en[2] !== 1'b0) begin errors++; $display("FAIL wake_regate: got %b want 0", clk_en[2]); end
    checks++; if (clk_en !== m_en) begin errors++; $display("FAIL wake_final_en: got %h want %h", clk_en, m_en); end
  endtask

  task automatic test_overrides();
    int bad;
    do_reset();
    thr = 8'd0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      checks++; if (clk_en !== 4'hF) begin errors++; bad++; if (bad < 4) $display("FAIL thr0_no_gate[%0d]: got %h want f", i, clk_en); end
    end
    thr = 8'd2;
    force_on = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (clk_en !== m_en) begin errors++; $display("FAIL force_en[%0d]: got %h want %h", i, clk_en, m_en); end
    end
    checks++; if (clk_en !== 4'b0001) begin errors++; $display("FAIL force_hold: got %h want 1", clk_en); end
    force_on = 4'b1001;
    tick();
    checks++; if (clk_en[3] !== 1'b1) begin errors++; $display("FAIL force_wake: got %b want 1", clk_en[3]); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (clk_en !== m_en || ack !== m_ack) begin errors++; $display("FAIL force_wake_seq[%0d]: got en=%h ack=%h want en=%h ack=%h", i, clk_en, ack, m_en, m_ack); end
    end
    force_on = '0;
  endtask

  task automatic test_random_glitch();
    int bad;
    do_reset();
    thr = 8'd10;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (i == 40) thr = 8'd1;
      for (int g = 0; g < NCH; g++) begin
        busy[g]     = ($urandom_range(0, 7) == 0);
        force_on[g] = ($urandom_range(0, 15) == 0);
        if (wake_req[g]) begin
          if (m_ack[g] && $urandom_range(0, 3) == 0) wake_req[g] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          wake_req[g] = 1'b1;
        end
      end
      tick();
      checks++;
      if (clk_en !== m_en || ack !== m_ack) begin
        errors++; bad++;
        if (bad < 6) $display("FAIL random[%0d]: got en=%h ack=%h want en=%h ack=%h", i, clk_en, ack, m_en, m_ack);
      end
    end
    busy = '0; force_on = '0; wake_req = '0;
    checks++; if (glitches != 0) begin errors++; $display("FAIL glitch_count: got %0d want 0", glitches); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    thr = 8'd2;
    tick();
    tick();
    checks++; if (clk_en !== 4'h0) begin errors++; $display("FAIL mid_all_off: got %h want 0", clk_en); end
    wake_req = 4'b0010;
    tick();
    checks++; if (clk_en !== 4'b0010) begin errors++; $display("FAIL mid_waking: got %h want 2", clk_en); end
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (clk_en !== 4'hF) begin errors++; $display("FAIL mid_reset_en: got %h want f", clk_en); end
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL mid_reset_ack: got %h want 0", ack); end
    wake_req = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (clk_en !== m_en || ack !== m_ack) begin errors++; $display("FAIL mid_after[%0d]: got en=%h ack=%h want en=%h ack=%h", i, clk_en, ack, m_en, m_ack); end
    end
    checks++; if (glitches != 0) begin errors++; $display("FAIL mid_glitch: got %0d want 0", glitches); end
  endtask

  initial begin
    rst = 1'b1; thr = '0; busy = '0; force_on = '0; wake_req = '0;
    model_reset();
    test_reset();
    test_idle_restart();
    test_wake_handshake();
    test_overrides();
    test_random_glitch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clock_gate_ctrl.md
# clock_gate_ctrl

Multi-channel, idle-driven clock gating controller. Each of NUM_CH channels runs an independent state machine that shuts its clock off after a programmable number of consecutive idle cycles. The channel restarts the clock on activity, and a request/acknowledge handshake tells the requester when its clock has been stable for WAKE_CYCLES. The block sits between the core clock and the per-unit clock trees of the AQM datapath, with one glitch-free latch-based gate cell per channel.

## Interface
Parameters:
- NUM_CH, 4: number of independently gated channels (≥1)
- IDLE_W, 8: width of idle counter and threshold
- WAKE_CYCLES, 2: clock edges a channel must run in WAKE before it reports ready (≥1)

Ports:
- clk  in  1  ungated source clock
- rst  in  1  reset, asynchronous, active-high
- i__idle_threshold  in  IDLE_W  consecutive idle cycles before gating, shared by all channels; 0 disables gating
- i__busy  in  NUM_CH  per-channel activity indication
- i__force_on  in  NUM_CH  per-channel override that prevents gating and wakes an OFF channel
- i__wake_req  in  NUM_CH  per-channel level wake request, held until acknowledged
- o__wake_ack  out  NUM_CH  per-channel registered acknowledge; clock running and stable
- o__clk_en  out  NUM_CH  per-channel registered enable fed to the gate cell
- o__gated_clk  out  NUM_CH  per-channel gated clock

## Operation
- Per-channel state: ST_ON, ST_OFF, ST_WAKE. Activity is defined as act = busy | force_on | wake_req. Idle is !act.
- Reset, asynchronous: state = ST_ON, idle_cnt = 0, wake_cnt = 0, o__clk_en = all ones, o__wake_ack = 0. Clocks run during and after reset.
- ST_ON, o__clk_en = 1:
  - On act, idle_cnt clears to 0.
  - On idle, idle_cnt increments and saturates at all ones.
  - The channel moves to ST_OFF on an idle cycle when threshold ≠ 0 and idle_cnt ≥ threshold−1, i.e. after exactly threshold consecutive idle cycles.
  - With threshold = 0, the channel never leaves ST_ON.
- ST_OFF, o__clk_en = 0:
  - idle_cnt is held at 0.
  - On act, the channel moves to ST_WAKE and wake_cnt is set to 0.
- ST_WAKE, o__clk_en = 1:
  - wake_cnt increments every cycle.
  - When wake_cnt == WAKE_CYCLES−1, the channel moves to ST_ON with idle_cnt = 0.
  - Inputs are ignored in this state; WAKE always completes.
- o__clk_en is registered. Its next value is 1 unless the next state is ST_OFF.
- o__wake_ack:
  - Next value = (next state == ST_ON) & wake_req.
  - It stays high while wake_req is held and drops the cycle after wake_req drops.
  - While wake_req is high the channel cannot gate.
- Threshold changes take effect immediately. If a channel's idle_cnt already meets the new threshold, it gates on its next idle cycle.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Timing
- Gate cell:
  - The latch is transparent while clk is low and captures o__clk_en.
  - o__gated_clk = clk & latched_en, so there are no glitches or truncated pulses.
- Gating off: if o__clk_en falls at edge k, gated edge k still occurs and edges k+1 onward are suppressed.
- Gating on: if o__clk_en rises at edge k, the first gated edge is k+1.
- Gate latency: threshold consecutive idle cycles at inputs gives o__clk_en = 0 at the threshold-th edge.
- Wake latency from act sampled at edge k in ST_OFF:
  - o__clk_en = 1 after edge k.
  - ST_ON after edge k+WAKE_CYCLES.
  - o__wake_ack = 1 after the same edge.
- Reset asserted mid-operation forces o__clk_en high immediately. The gated clock resumes at the next low-phase latch update.

## Structure
- Package clock_gate_pkg holds:
  - the state enum typedef gate_state_t {ST_ON, ST_OFF, ST_WAKE};
  - its width constant;
  - default parameter constants.
- Sub-module clock_gate_cell: the latch and AND gate, one instance per channel via generate.
- FSMs and counters live in clock_gate_ctrl as per-channel arrays.

## Test plan
- Reset behaviour: reset with busy = 0 and threshold = 4 → o__clk_en = 4'hF and o__wake_ack = 0 during reset; after release, ch0 clk_en falls at the 4th edge and exactly 4 gated pulses appear after release.
- Idle-streak restart: threshold = 3, busy pulse on ch1 at idle cycle 2 → idle count restarts, and ch1 gates 3 cycles after the pulse; other channels gate at cycle 3.
- Wake handshake: ch2 OFF with WAKE_CYCLES = 2, raise wake_req → clk_en rises after 1 edge, ack rises 2 edges later, ack drops 1 cycle after req drops, and ch2 gates again after threshold idle cycles.
- Overrides: threshold = 0 → no gating for 1000 idle cycles; force_on held → never gates; force_on on an OFF channel wakes it.
- Glitch check: random busy, force_on and wake_req on all 4 channels, with threshold changed from 10 to 1 mid-count → every gated pulse has full high width, and a channel with idle_cnt ≥ 0 gates on its next idle cycle.
- Reset mid-WAKE and mid-OFF → o__clk_en is 1 immediately and ack is 0, with all channels returning to ST_ON.
